matrix_stream_sequencer: RTL and testbench

- Front/back-end stage for matrix_mult.
- Accepts A then B as a row-major element stream over valid/ready and packs them into flat buses.
- Pulses a per-job clear into the multiplier, holds its enable, and waits for rdy.
- Captures C and replays it as a row-major element stream with last marker. One job in flight at a time.

---
 rtl/matrix_stream_sequencer_pkg.sv | 23 ++
 rtl/matrix_stream_sequencer_pack_reg.sv | 31 +++
 rtl/matrix_stream_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_matrix_stream_sequencer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_stream_sequencer_pkg.sv
// Shared types and helpers for the matrix stream sequencer.
// Holds the sequencer state encoding, default geometry and the
// element slot-offset helper used by the flat packed buses.
package matrix_stream_sequencer_pkg;

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        CLEAR,
        RUN,
        DRAIN
    } seq_state_t;

    localparam int ORDER_DEFAULT    = 2;
    localparam int BITWIDTH_DEFAULT = 8;
    localparam int ELEMS            = ORDER_DEFAULT * ORDER_DEFAULT;

    // Bit offset of element slot idx in a flat bus of width-bit elements.
    function automatic int slotOffset(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/matrix_stream_sequencer_pack_reg.sv
// Write-addressed flat register: ELEMS slots of WIDTH bits packed into one
// bus, slot k at bit k*WIDTH. One slot can be written per cycle.
module matseq_pack_reg
    import matrix_stream_sequencer_pkg::*;
#(
    parameter int ELEMS = 4,
    parameter int WIDTH = 8,
    localparam int IDXW = (ELEMS > 1) ? $clog2(ELEMS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en_i,
    input  logic [IDXW-1:0]          wr_idx_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic [ELEMS*WIDTH-1:0]   data_o
);

    logic [ELEMS*WIDTH-1:0] data_q;

    // Store the incoming element into its addressed slot; other slots hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q <= '0;
        end else if (wr_en_i) begin
            data_q[slotOffset(int'(wr_idx_i), WIDTH) +: WIDTH] <= wr_data_i;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/matrix_stream_sequencer.sv
// Front/back-end stage for matrix_mult: collects A then B as a row-major
// element stream, pulses the multiplier clear, holds enable until the
// multiplier reports rdy, then replays the captured C as a row-major stream
// with a last marker. Only one job is in flight at a time.
// Optional build macro MATSEQ_TIMEOUT_EN adds a RUN-state watchdog and the
// sticky timeout_err output.
module matrix_stream_sequencer
    import matrix_stream_sequencer_pkg::*;
#(
    parameter int order          = ORDER_DEFAULT,
    parameter int bitwidth       = BITWIDTH_DEFAULT,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [bitwidth-1:0]                in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [bitwidth-1:0]                out_data,
    output logic                               out_last,
    output logic                               busy,
    output logic                               mult_clear,
    output logic                               mult_enable,
    output logic [order*order*bitwidth-1:0]    mult_A,
    output logic [order*order*bitwidth-1:0]    mult_B,
    input  logic [order*order*bitwidth-1:0]    mult_C,
    input  logic                               mult_rdy
`ifdef MATSEQ_TIMEOUT_EN
    ,
    output logic                               timeout_err
`endif
);

    localparam int NUM_ELEMS = order * order;
    localparam int IDXW      = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_ELEMS - 1);

    // The watchdog must leave room for the multiplier's normal latency.
    generate
        if (TIMEOUT_CYCLES <= order * order * order + 2) begin : gTimeoutCheck
            $error("TIMEOUT_CYCLES must exceed order^3+2");
        end
    endgenerate

    seq_state_t state_q, state_d;
    logic [IDXW-1:0] cnt_q, cnt_d;
    logic [NUM_ELEMS*bitwidth-1:0] cap_q;
    logic aWr, bWr, capLoad;
    logic timeoutHit;

`ifdef MATSEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] LAST_TMR = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] tmr_q;
    logic timeoutErr_q;

    assign timeoutHit = (state_q == RUN) && !mult_rdy && (tmr_q == LAST_TMR);

    // Count cycles spent in RUN; restart from zero whenever RUN is left.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmr_q <= '0;
        end else if (state_q == RUN) begin
            tmr_q <= tmr_q + TW'(1);
        end else begin
            tmr_q <= '0;
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeoutErr_q <= 1'b0;
        end else if (timeoutHit) begin
            timeoutErr_q <= 1'b1;
        end
    end

    assign timeout_err = timeoutErr_q;
`else
    assign timeoutHit = 1'b0;
`endif

    // State and element counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= LOAD_A;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Capture the multiplier result in the cycle rdy is seen during RUN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cap_q <= '0;
        end else if (capLoad) begin
            cap_q <= mult_C;
        end
    end

    // Next-state and counter sequencing across load, compute and drain.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOAD_A: begin
                if (in_valid) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = LOAD_B;
                    end else begin
                        cnt_d = cnt_q + IDXW'(1);
                    end
                end
            end
            LOAD_B: begin
                if (in_valid) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = CLEAR;
                    end else begin
                        cnt_d = cnt_q + IDXW'(1);
                    end
                end
            end
            CLEAR: begin
                state_d = RUN;
            end
            RUN: begin
                if (mult_rdy) begin
                    cnt_d   = '0;
                    state_d = DRAIN;
                end else if (timeoutHit) begin
                    cnt_d   = '0;
                    state_d = LOAD_A;
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d   = '0;
                        state_d = LOAD_A;
                    end else begin
                        cnt_d = cnt_q + IDXW'(1);
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = LOAD_A;
            end
        endcase
    end

    // Handshake, multiplier control and output data decoded from state.
    always_comb begin
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_last    = 1'b0;
        mult_clear  = 1'b0;
        mult_enable = 1'b0;
        aWr         = 1'b0;
        bWr         = 1'b0;
        capLoad     = 1'b0;
        busy        = !((state_q == LOAD_A) && (cnt_q == '0));
        case (state_q)
            LOAD_A: begin
                in_ready = 1'b1;
                aWr      = in_valid;
            end
            LOAD_B: begin
                in_ready = 1'b1;
                bWr      = in_valid;
            end
            CLEAR: begin
                mult_clear = 1'b1;
            end
            RUN: begin
                mult_enable = 1'b1;
                capLoad     = mult_rdy;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_data  = cap_q[slotOffset(int'(cnt_q), bitwidth) +: bitwidth];
                out_last  = (cnt_q == LAST_IDX);
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    matseq_pack_reg #(
        .ELEMS (NUM_ELEMS),
        .WIDTH (bitwidth)
    ) uPackA (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (aWr),
        .wr_idx_i  (cnt_q),
        .wr_data_i (in_data),
        .data_o    (mult_A)
    );

    matseq_pack_reg #(
        .ELEMS (NUM_ELEMS),
        .WIDTH (bitwidth)
    ) uPackB (
        .clk       (clk),
        .reset     (reset),
        .wr_en_i   (bWr),
        .wr_idx_i  (cnt_q),
        .wr_data_i (in_data),
        .data_o    (mult_B)
    );

endmodule

// File: tb/tb_matrix_stream_sequencer.sv
// Testbench for matrix_stream_sequencer with a behavioural multiplier stub
// and a reference model computing C = A*B modulo 2^bitwidth.
// Build with MATSEQ_TIMEOUT_EN defined to also exercise the watchdog.
module tb_matrix_stream_sequencer;

    localparam int ORDER = 2;
    localparam int BW    = 8;
    localparam int ELEMS = ORDER * ORDER;
    localparam int TMO   = 64;
    localparam int LAT   = ORDER * ORDER * ORDER + 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [BW-1:0]         in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [BW-1:0]         out_data;
    logic                  out_last;
    logic                  busy;
    logic                  mult_clear;
    logic                  mult_enable;
    logic [ELEMS*BW-1:0]   mult_A;
    logic [ELEMS*BW-1:0]   mult_B;
    logic [ELEMS*BW-1:0]   mult_C;
    logic                  mult_rdy;
`ifdef MATSEQ_TIMEOUT_EN
    logic                  timeout_err;
`endif

    logic stubRdy;
    logic spurRdy;
    logic noRdy;
    int   stubCnt;

    int vectors = 0;
    int miscompares = 0;

    logic [BW-1:0] jobA [ELEMS];
    logic [BW-1:0] jobB [ELEMS];
    logic [BW-1:0] expC [ELEMS];

    matrix_stream_sequencer #(
        .order          (ORDER),
        .bitwidth       (BW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .mult_clear  (mult_clear),
        .mult_enable (mult_enable),
        .mult_A      (mult_A),
        .mult_B      (mult_B),
        .mult_C      (mult_C),
        .mult_rdy    (mult_rdy)
`ifdef MATSEQ_TIMEOUT_EN
        ,
        .timeout_err (timeout_err)
`endif
    );

    always #5 clk = ~clk;

    // Multiplier product computed on the flat buses, truncated to BW bits.
    function automatic logic [ELEMS*BW-1:0] mulFlat(input logic [ELEMS*BW-1:0] a,
                                                    input logic [ELEMS*BW-1:0] b);
        logic [ELEMS*BW-1:0] r;
        logic [BW-1:0] acc;
        r = '0;
        for (int i = 0; i < ORDER; i++) begin
            for (int j = 0; j < ORDER; j++) begin
                acc = '0;
                for (int k = 0; k < ORDER; k++) begin
                    acc = acc + a[(i*ORDER+k)*BW +: BW] * b[(k*ORDER+j)*BW +: BW];
                end
                r[(i*ORDER+j)*BW +: BW] = acc;
            end
        end
        return r;
    endfunction

    // Multiplier stub: result appears LAT cycles after the clear pulse.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            stubRdy <= 1'b0;
            stubCnt <= 0;
            mult_C  <= '0;
        end else if (mult_clear) begin
            stubCnt <= LAT;
            stubRdy <= 1'b0;
        end else if (mult_enable) begin
            if (stubCnt > 1) begin
                stubCnt <= stubCnt - 1;
            end else if (stubCnt == 1 && !noRdy) begin
                stubCnt <= 0;
                stubRdy <= 1'b1;
                mult_C  <= mulFlat(mult_A, mult_B);
            end
        end else begin
            stubRdy <= 1'b0;
        end
    end

    assign mult_rdy = stubRdy | spurRdy;

    // Reference model: row-major element idx of A*B modulo 2^BW.
    function automatic logic [BW-1:0] refElem(input int idx);
        int unsigned s;
        int i;
        int j;
        i = idx / ORDER;
        j = idx % ORDER;
        s = 0;
        for (int k = 0; k < ORDER; k++) begin
            s = s + int'(jobA[i*ORDER+k]) * int'(jobB[k*ORDER+j]);
        end
        return BW'(s % (1 << BW));
    endfunction

    task automatic setExpFromModel();
        for (int i = 0; i < ELEMS; i++) expC[i] = refElem(i);
    endtask

    task automatic randomJob();
        for (int i = 0; i < ELEMS; i++) begin
            jobA[i] = BW'($urandom);
            jobB[i] = BW'($urandom);
        end
        setExpFromModel();
    endtask

    task automatic pushElem(input logic [BW-1:0] d, input int idle);
        int k;
        repeat (idle) @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        k = 0;
        while (!in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL push_accept in_ready got %0b want 1 (data %0d)", in_ready, d);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = BW'($urandom);
    endtask

    task automatic loadJob(input int idleMin, input int idleMax, input bit spur);
        spurRdy = spur;
        for (int i = 0; i < ELEMS; i++) begin
            pushElem(jobA[i], $urandom_range(idleMax, idleMin));
            if (i == 0) begin
                vectors++;
                if (busy !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL busy_after_first got %0b want 1", busy);
                end
            end
        end
        spurRdy = 1'b0;
        for (int i = 0; i < ELEMS; i++) pushElem(jobB[i], $urandom_range(idleMax, idleMin));
    endtask

    task automatic drainJob(input int stallIdx, input bit randReady);
        int idx = 0;
        int cyc = 0;
        int stallLeft = 0;
        int clears = 0;
        bit stallDone = 0;
        bit sawEn = 0;
        logic [ELEMS*BW-1:0] packA;
        logic [ELEMS*BW-1:0] packB;
        for (int i = 0; i < ELEMS; i++) begin
            packA[i*BW +: BW] = jobA[i];
            packB[i*BW +: BW] = jobB[i];
        end
        while (idx < ELEMS && cyc < 500) begin
            if (mult_clear) clears++;
            if (mult_clear || mult_enable || out_valid) begin
                vectors++;
                if (in_ready !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL in_ready_busy got %0b want 0", in_ready);
                end
            end
            if (mult_enable && !sawEn) begin
                sawEn = 1;
                vectors += 2;
                if (mult_A !== packA) begin
                    miscompares++;
                    $display("[TB] FAIL mult_A got %h want %h", mult_A, packA);
                end
                if (mult_B !== packB) begin
                    miscompares++;
                    $display("[TB] FAIL mult_B got %h want %h", mult_B, packB);
                end
            end
            if (out_valid && idx == stallIdx && !stallDone) begin
                stallDone = 1;
                stallLeft = 3;
            end
            if (stallLeft > 0) begin
                out_ready = 1'b0;
                stallLeft--;
            end else begin
                out_ready = randReady ? 1'($urandom_range(1, 0)) : 1'b1;
            end
            if (out_valid) begin
                vectors += 2;
                if (out_data !== expC[idx]) begin
                    miscompares++;
                    $display("[TB] FAIL out_data[%0d] got %0d want %0d", idx, out_data, expC[idx]);
                end
                if (out_last !== (idx == ELEMS - 1)) begin
                    miscompares++;
                    $display("[TB] FAIL out_last[%0d] got %0b want %0b", idx, out_last, idx == ELEMS - 1);
                end
                if (out_ready) idx++;
            end
            @(negedge clk);
            cyc++;
        end
        out_ready = 1'b0;
        vectors += 7;
        if (idx != ELEMS) begin
            miscompares++;
            $display("[TB] FAIL drain_count got %0d want %0d", idx, ELEMS);
        end
        if (clears != 1) begin
            miscompares++;
            $display("[TB] FAIL clear_pulses got %0d want 1", clears);
        end
        if (sawEn != 1'b1) begin
            miscompares++;
            $display("[TB] FAIL saw_enable got %0b want 1", sawEn);
        end
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_out_valid got %0b want 0", out_valid);
        end
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL post_in_ready got %0b want 1", in_ready);
        end
        if (busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_busy got %0b want 0", busy);
        end
        if (out_last !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL post_out_last got %0b want 0", out_last);
        end
    endtask

    task automatic checkResetValues(input string tag);
        vectors += 9;
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL %s in_ready got %0b want 1", tag, in_ready); end
        if (out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL %s out_valid got %0b want 0", tag, out_valid); end
        if (out_last !== 1'b0) begin miscompares++; $display("[TB] FAIL %s out_last got %0b want 0", tag, out_last); end
        if (out_data !== '0) begin miscompares++; $display("[TB] FAIL %s out_data got %0d want 0", tag, out_data); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL %s busy got %0b want 0", tag, busy); end
        if (mult_clear !== 1'b0) begin miscompares++; $display("[TB] FAIL %s mult_clear got %0b want 0", tag, mult_clear); end
        if (mult_enable !== 1'b0) begin miscompares++; $display("[TB] FAIL %s mult_enable got %0b want 0", tag, mult_enable); end
        if (mult_A !== '0) begin miscompares++; $display("[TB] FAIL %s mult_A got %h want 0", tag, mult_A); end
        if (mult_B !== '0) begin miscompares++; $display("[TB] FAIL %s mult_B got %h want 0", tag, mult_B); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checkResetValues("reset");
`ifdef MATSEQ_TIMEOUT_EN
        vectors++;
        if (timeout_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_timeout_err got %0b want 0", timeout_err);
        end
`endif
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        jobA = '{8'd1, 8'd2, 8'd3, 8'd4};
        jobB = '{8'd5, 8'd6, 8'd7, 8'd8};
        expC = '{8'd19, 8'd22, 8'd43, 8'd50};
        loadJob(0, 0, 1'b1);
        drainJob(-1, 1'b0);
    endtask

    task automatic test_stalls();
        jobA = '{8'd1, 8'd2, 8'd3, 8'd4};
        jobB = '{8'd5, 8'd6, 8'd7, 8'd8};
        expC = '{8'd19, 8'd22, 8'd43, 8'd50};
        loadJob(1, 1, 1'b0);
        drainJob(2, 1'b0);
    endtask

    task automatic test_back_to_back();
        randomJob();
        loadJob(0, 0, 1'b0);
        drainJob(-1, 1'b0);
        jobA = '{8'd1, 8'd0, 8'd0, 8'd1};
        jobB = '{8'd9, 8'd8, 8'd7, 8'd6};
        expC = '{8'd9, 8'd8, 8'd7, 8'd6};
        loadJob(0, 0, 1'b0);
        drainJob(-1, 1'b0);
    endtask

    task automatic test_reset_mid();
        randomJob();
        for (int i = 0; i < ELEMS; i++) pushElem(jobA[i], 0);
        for (int i = 0; i < ELEMS - 1; i++) pushElem(jobB[i], 0);
        reset = 1'b1;
        #1;
        checkResetValues("reset_mid");
        @(negedge clk);
        reset = 1'b0;
        randomJob();
        loadJob(0, 1, 1'b0);
        drainJob(1, 1'b0);
    endtask

    task automatic test_overflow();
        jobA = '{8'd16, 8'd16, 8'd16, 8'd16};
        jobB = '{8'd16, 8'd16, 8'd16, 8'd16};
        expC = '{8'd0, 8'd0, 8'd0, 8'd0};
        loadJob(0, 0, 1'b0);
        drainJob(-1, 1'b0);
    endtask

    task automatic test_random_jobs();
        for (int n = 0; n < 6; n++) begin
            randomJob();
            loadJob(0, 2, 1'b0);
            drainJob(-1, 1'b1);
        end
    endtask

`ifdef MATSEQ_TIMEOUT_EN
    task automatic test_timeout();
        int en = 0;
        int cyc = 0;
        bit sawValid = 0;
        noRdy = 1'b1;
        randomJob();
        loadJob(0, 0, 1'b0);
        while (cyc < 500) begin
            if (out_valid) sawValid = 1;
            if (mult_enable) en++;
            if (en > 0 && !mult_enable) break;
            @(negedge clk);
            cyc++;
        end
        noRdy = 1'b0;
        vectors += 5;
        if (en != TMO) begin miscompares++; $display("[TB] FAIL tmo_run_cycles got %0d want %0d", en, TMO); end
        if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_err got %0b want 1", timeout_err); end
        if (sawValid) begin miscompares++; $display("[TB] FAIL tmo_out_valid got 1 want 0"); end
        if (in_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_in_ready got %0b want 1", in_ready); end
        if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_busy got %0b want 0", busy); end
        randomJob();
        loadJob(0, 0, 1'b0);
        drainJob(-1, 1'b0);
        vectors++;
        if (timeout_err !== 1'b1) begin miscompares++; $display("[TB] FAIL tmo_sticky got %0b want 1", timeout_err); end
        reset = 1'b1;
        #1;
        vectors++;
        if (timeout_err !== 1'b0) begin miscompares++; $display("[TB] FAIL tmo_clear got %0b want 0", timeout_err); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask
`endif

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        spurRdy   = 1'b0;
        noRdy     = 1'b0;
        test_reset();
        test_basic();
        test_stalls();
        test_back_to_back();
        test_reset_mid();
        test_overflow();
        test_random_jobs();
`ifdef MATSEQ_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
